// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing a 2-stage registered logic unit among N_REQ requesters.
// Define ARB_FIXED_PRIO_EN to build a fixed-priority (lowest index wins) arbiter with no pointer register.
module logic_unit_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 2
) (
    input  logic                      clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_a,
    input  logic [N_REQ*DATA_W-1:0]   i_b,
    input  logic [N_REQ*2-1:0]        i_op,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_res_valid,
    output logic [ID_W-1:0]           o_res_id,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_busy,
    output logic [1:0]                o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_or_q, s1_or_d;
    logic [DATA_W-1:0]   s1_and_q, s1_and_d;
    logic [1:0]          s1_op_q, s1_op_d;
    logic [ID_W-1:0]     s1_id_q, s1_id_d;
    logic                s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]   s2_data_q, s2_data_d;
    logic [ID_W-1:0]     s2_id_q, s2_id_d;
    logic                busy_q, busy_d;

    logic [ID_W-1:0]     rp_val;
    logic [N_REQ-1:0]    gnt_c;
    logic [ID_W-1:0]     gnt_id_c;
    logic                gnt_any_c;
    logic [ID_W-1:0]     search_idx;
    logic [DATA_W-1:0]   a_sel, b_sel, comb_res;
    logic [1:0]          op_sel;

    logic [DATA_W-1:0]   a_arr  [N_REQ];
    logic [DATA_W-1:0]   b_arr  [N_REQ];
    logic [1:0]          op_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign a_arr[g]  = i_a[g*DATA_W +: DATA_W];
        assign b_arr[g]  = i_b[g*DATA_W +: DATA_W];
        assign op_arr[g] = i_op[g*2 +: 2];
    end

`ifdef ARB_FIXED_PRIO_EN
    assign rp_val = '0;
`else
    logic [ID_W-1:0] rp_q, rp_d;
    assign rp_val = rp_q;
`endif

    // Wrapping search from the pointer; first requesting index wins, only while running.
    always_comb begin
        gnt_c      = '0;
        gnt_id_c   = '0;
        gnt_any_c  = 1'b0;
        search_idx = '0;
        if (state_q == ST_RUN) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                search_idx = ID_W'((32'(rp_val) + i) % N_REQ);
                if (!gnt_any_c && i_req[search_idx]) begin
                    gnt_any_c          = 1'b1;
                    gnt_id_c           = search_idx;
                    gnt_c[search_idx]  = 1'b1;
                end
            end
        end
    end

    assign a_sel  = a_arr[gnt_id_c];
    assign b_sel  = b_arr[gnt_id_c];
    assign op_sel = op_arr[gnt_id_c];

    always_comb begin
        case (s1_op_q)
            2'b00:   comb_res = s1_or_q;
            2'b01:   comb_res = s1_and_q;
            2'b10:   comb_res = s1_or_q & ~s1_and_q;
            default: comb_res = s1_or_q | s1_and_q;
        endcase
    end

    // Next-state: controller, pointer and both pipeline stages.
    always_comb begin
        state_d    = state_q;
        s1_valid_d = gnt_any_c;
        s1_or_d    = s1_or_q;
        s1_and_d   = s1_and_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        busy_d     = gnt_any_c | s1_valid_q;
`ifndef ARB_FIXED_PRIO_EN
        rp_d       = rp_q;
        if (gnt_any_c) begin
            rp_d = ID_W'((32'(gnt_id_c) + 32'd1) % N_REQ);
        end
`endif
        if (gnt_any_c) begin
            s1_or_d  = a_sel | b_sel;
            s1_and_d = a_sel & b_sel;
            s1_op_d  = op_sel;
            s1_id_d  = gnt_id_c;
        end
        if (s1_valid_q) begin
            s2_data_d = comb_res;
            s2_id_d   = s1_id_q;
        end
        case (state_q)
            ST_IDLE:  if (i_enable) state_d = ST_RUN;
            ST_RUN:   if (!i_enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                end else if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_or_q    <= '0;
            s1_and_q   <= '0;
            s1_op_q    <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            busy_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rp_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_or_q    <= s1_or_d;
            s1_and_q   <= s1_and_d;
            s1_op_q    <= s1_op_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            busy_q     <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            rp_q       <= rp_d;
`endif
        end
    end

    assign o_gnt       = gnt_c;
    assign o_res_valid = s2_valid_q;
    assign o_res_id    = s2_id_q;
    assign o_data      = s2_data_q;
    assign o_busy      = busy_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a behavioural model predicts grants, state and
// results; directed sequences cover the basic op, fairness, opcode sweep, drain and async reset.
module tb_logic_unit_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ID_W   = 2;

    logic                    clock = 1'b0;
    logic                    i_reset_n = 1'b0;
    logic                    i_enable = 1'b0;
    logic [N_REQ-1:0]        i_req = '0;
    logic [N_REQ*DATA_W-1:0] i_a;
    logic [N_REQ*DATA_W-1:0] i_b;
    logic [N_REQ*2-1:0]      i_op;
    logic [N_REQ-1:0]        o_gnt;
    logic                    o_res_valid;
    logic [ID_W-1:0]         o_res_id;
    logic [DATA_W-1:0]       o_data;
    logic                    o_busy;
    logic [1:0]              o_state;

    logic [DATA_W-1:0] ta [N_REQ];
    logic [DATA_W-1:0] tbv [N_REQ];
    logic [1:0]        top [N_REQ];

    assign i_a  = {ta[3], ta[2], ta[1], ta[0]};
    assign i_b  = {tbv[3], tbv[2], tbv[1], tbv[0]};
    assign i_op = {top[3], top[2], top[1], top[0]};

    always #5 clock = ~clock;

    logic_unit_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clock       (clock),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_req       (i_req),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_op        (i_op),
        .o_gnt       (o_gnt),
        .o_res_valid (o_res_valid),
        .o_res_id    (o_res_id),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_state     (o_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] lu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [1:0] op);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic int gnt_index(input logic [N_REQ-1:0] g);
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (((32'(g) >> i) & 32'd1) != 0) return i;
        end
        return -1;
    endfunction

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state, advanced at each negedge to predict the following rising edge.
    logic [1:0]      m_state = 2'b00;
    logic [1:0]      m_rp = 2'd0;
    logic            m_v1 = 1'b0;
    logic            m_v2 = 1'b0;
    int              cyc = 0;

    always @(negedge clock) begin
        logic [N_REQ-1:0] exp_gnt;
        logic [1:0]       idx;
        logic [1:0]       win;
        logic             acc;
        exp_t             e;
        if (!i_reset_n) begin
            m_state = 2'b00;
            m_rp    = 2'd0;
            m_v1    = 1'b0;
            m_v2    = 1'b0;
            sb_q.delete();
        end else begin
            cyc++;
            if (o_res_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("res_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("res_id", 32'(o_res_id), 32'(e.id));
                    check_eq("res_data", 32'(o_data), 32'(e.data));
                    check_eq("res_cycle", cyc, e.cyc);
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                check_eq("res_missing", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
            exp_gnt = '0;
            acc     = 1'b0;
            win     = 2'd0;
            if (m_state == 2'b01) begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    idx = 2'((int'(m_rp) + i) % int'(N_REQ));
                    if (!acc && i_req[idx]) begin
                        acc          = 1'b1;
                        win          = idx;
                        exp_gnt[idx] = 1'b1;
                    end
                end
            end
            check_eq("gnt", 32'(o_gnt), 32'(exp_gnt));
            check_eq("state", 32'(o_state), 32'(m_state));
            check_eq("busy", 32'(o_busy), 32'(m_v1 | m_v2));
            if (acc) begin
                e.id   = win;
                e.data = lu_ref(ta[win], tbv[win], top[win]);
                e.cyc  = cyc + 2;
                sb_q.push_back(e);
`ifndef ARB_FIXED_PRIO_EN
                m_rp = win + 2'd1;
`endif
            end
            case (m_state)
                2'b00:   if (i_enable) m_state = 2'b01;
                2'b01:   if (!i_enable) m_state = 2'b10;
                default: begin
                    if (i_enable) m_state = 2'b01;
                    else if (!m_v1 && !m_v2) m_state = 2'b00;
                end
            endcase
            m_v2 = m_v1;
            m_v1 = acc;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tick();
        i_reset_n = 1'b0;
        i_enable  = 1'b0;
        i_req     = '0;
        tick();
        tick();
        i_reset_n = 1'b1;
    endtask

    // Present one request and hold it until granted; returns in the cycle after the grant.
    task automatic req_one(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        bit got = 0;
        ta[k]    = a;
        tbv[k]   = b;
        top[k]   = op;
        i_req[k] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            if (o_gnt[k]) got = 1;
        end
        check_eq("gnt_wait", 32'(got), 32'd1);
        tick();
        i_req[k] = 1'b0;
    endtask

    task automatic expect_res(input logic [1:0] id, input logic [7:0] data);
        @(negedge clock);
        @(negedge clock);
        check_eq("dir_valid", 32'(o_res_valid), 32'd1);
        check_eq("dir_id", 32'(o_res_id), 32'(id));
        check_eq("dir_data", 32'(o_data), 32'(data));
    endtask

    logic [7:0] sweep_exp [4];
    int res_cnt;
    int gi;
    bit got_g;

    initial begin
        for (int k = 0; k < int'(N_REQ); k++) begin
            ta[k] = '0; tbv[k] = '0; top[k] = '0;
        end
        sweep_exp[0] = 8'hAF; sweep_exp[1] = 8'h0A; sweep_exp[2] = 8'hA5; sweep_exp[3] = 8'hAF;

        // Reset state and the basic XOR transaction.
        do_reset();
        check_eq("rst_valid", 32'(o_res_valid), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_id", 32'(o_res_id), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_state", 32'(o_state), 32'd0);
        i_enable = 1'b1;
        req_one(2'd0, 8'hF0, 8'h3C, 2'b10);
        check_eq("run_state", 32'(o_state), 32'd1);
        expect_res(2'd0, 8'hCC);

        // Fairness with all four requesting.
        do_reset();
        i_enable = 1'b1;
        tick();
        for (int k = 0; k < int'(N_REQ); k++) begin
            ta[k] = 8'($urandom); tbv[k] = 8'($urandom); top[k] = 2'($urandom);
        end
        i_req = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
`ifdef ARB_FIXED_PRIO_EN
            check_eq("fair_gnt", 32'(gnt_index(o_gnt)), 32'd0);
`else
            check_eq("fair_gnt", 32'(gnt_index(o_gnt)), 32'(i % 4));
`endif
            if (i >= 2) check_eq("fair_tput", 32'(o_res_valid), 32'd1);
        end
        tick();
        i_req = '0;
        repeat (4) tick();

        // Opcode sweep on requester 2.
        for (int j = 0; j < 4; j++) begin
            req_one(2'd2, 8'hAA, 8'h0F, 2'(j));
            expect_res(2'd2, sweep_exp[j]);
        end

        // Drain: two back-to-back grants, then stop.
        tick();
        ta[0] = 8'h12; tbv[0] = 8'h34; top[0] = 2'b01;
        ta[1] = 8'h56; tbv[1] = 8'h78; top[1] = 2'b11;
        i_req = 4'b0011;
        tick();
        tick();
        i_req    = '0;
        i_enable = 1'b0;
        res_cnt  = 0;
        @(negedge clock);
        if (o_res_valid) res_cnt++;
        tick();
        i_req = 4'hF;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (n == 0) check_eq("drain_state", 32'(o_state), 32'd2);
            if (o_res_valid) res_cnt++;
            check_eq("drain_nogrant", 32'(o_gnt), 32'd0);
        end
        check_eq("drain_results", res_cnt, 2);
        check_eq("drain_idle", 32'(o_state), 32'd0);
        check_eq("drain_busy", 32'(o_busy), 32'd0);
        tick();
        i_req = '0;

        // Async reset with two entries in flight.
        i_enable = 1'b1;
        tick();
        i_req = 4'b0011;
        tick();
        tick();
        i_req = '0;
        #1;
        i_reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(o_res_valid), 32'd0);
        check_eq("arst_data", 32'(o_data), 32'd0);
        check_eq("arst_id", 32'(o_res_id), 32'd0);
        check_eq("arst_busy", 32'(o_busy), 32'd0);
        check_eq("arst_state", 32'(o_state), 32'd0);
        tick();
        tick();
        i_reset_n = 1'b1;
        i_enable  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check_eq("arst_nopulse", 32'(o_res_valid), 32'd0);
        end
        tick();
        i_enable = 1'b1;
        i_req    = 4'hF;
        got_g    = 0;
        gi       = -1;
        for (int n = 0; n < 10 && !got_g; n++) begin
            @(negedge clock);
            if (o_gnt != '0) begin
                got_g = 1;
                gi    = gnt_index(o_gnt);
            end
        end
        check_eq("arst_first_gnt", 32'(gi), 32'd0);
        tick();
        i_req = '0;

`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: requester 1 always beats requester 2.
        i_req = 4'b0110;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            check_eq("fixed_gnt", 32'(o_gnt), 32'b0010);
        end
        tick();
        i_req = '0;
`endif

        repeat (4) tick();
        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule
